level_ctrl: RTL

Gameplay progress tracker that turns line-clear events into the `Level` value consumed by the drop-rate divider, plus score and total line count. It runs on the 25 MHz game clock and sits between the board logic, which reports cleared rows and game-over, and the drop divider and display. It drives `Level = 0` whenever no game is active, which halts gravity. Scoring multiplies a base value by the current level using a multi-cycle repeated add, gated by a valid/ready handshake.

---
 rtl/tetris_pkg.sv | 39 +++
 rtl/score_accum.sv | 52 +++++
 rtl/level_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared types and constants for the gameplay progress logic: FSM states,
// line-clear base scores and default level/score limits.
package tetris_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    ADD,
    OVER
  } state_t;

  localparam int unsigned SCORE_1 = 40;
  localparam int unsigned SCORE_2 = 100;
  localparam int unsigned SCORE_3 = 300;
  localparam int unsigned SCORE_4 = 1200;

  localparam int unsigned MAX_LEVEL_DEFAULT       = 20;
  localparam int unsigned LINES_PER_LEVEL_DEFAULT = 10;
  localparam int unsigned SCORE_MAX_DEFAULT       = 999999;

  localparam int BASE_W  = 11;  // holds SCORE_4
  localparam int CNT_W   = 5;   // iteration count, covers MAX_LEVEL
  localparam int SCORE_W = 20;

  function automatic logic [BASE_W-1:0] base_score(input logic [2:0] n);
    case (n)
      3'd1:    return BASE_W'(SCORE_1);
      3'd2:    return BASE_W'(SCORE_2);
      3'd3:    return BASE_W'(SCORE_3);
      3'd4:    return BASE_W'(SCORE_4);
      default: return '0;
    endcase
  endfunction

  function automatic logic lines_valid(input logic [2:0] n);
    return (n >= 3'd1) && (n <= 3'd4);
  endfunction

endpackage

// File: rtl/score_accum.sv
// Saturating repeated adder: on load, adds base to the running score once per
// cycle for count cycles; clear zeroes the score for a new game.
module score_accum
  import tetris_pkg::*;
#(
  parameter int unsigned SCORE_MAX = SCORE_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [BASE_W-1:0]  base,
  input  logic [CNT_W-1:0]   count,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               done
);

  localparam logic [SCORE_W:0] LIMIT = SCORE_MAX[SCORE_W:0];

  logic [BASE_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SCORE_W:0]  sum;

  // One bit wider than the score so the overflow is visible to the compare.
  assign sum  = {1'b0, score} + {{(SCORE_W + 1 - BASE_W){1'b0}}, base_q};
  assign done = busy && (cnt_q == CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score  <= '0;
      busy   <= 1'b0;
      base_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      score <= '0;
      busy  <= 1'b0;
      cnt_q <= '0;
    end else if (load && (count != '0)) begin
      base_q <= base;
      cnt_q  <= count;
      busy   <= 1'b1;
    end else if (busy) begin
      score <= (sum > LIMIT) ? LIMIT[SCORE_W-1:0] : sum[SCORE_W-1:0];
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/level_ctrl.sv
// Gameplay progress tracker: converts accepted line-clear events into Level,
// Lines and Score; Level is held at 0 outside an active game to stop gravity.
module level_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned LINES_PER_LEVEL = LINES_PER_LEVEL_DEFAULT,
  parameter int unsigned MAX_LEVEL       = MAX_LEVEL_DEFAULT,
  parameter int unsigned SCORE_MAX       = SCORE_MAX_DEFAULT
) (
  input  logic        CLK_25M,
  input  logic        RST_N,
  input  logic        Start,
  input  logic        Game_Over,
  input  logic        Clear_Valid,
  input  logic [2:0]  Clear_Lines,
  output logic        Clear_Ready,
  output logic [31:0] Level,
  output logic [19:0] Score,
  output logic [15:0] Lines,
  output logic        Level_Up
);

  localparam logic [4:0]  LPL  = LINES_PER_LEVEL[4:0];
  localparam logic [31:0] MAXL = MAX_LEVEL;

  state_t            state_q, state_d;
  logic [31:0]       level_d;
  logic [15:0]       lines_d;
  logic [3:0]        lvl_cnt_q, lvl_cnt_d;
  logic              level_up_d;
  logic              ready_d;

  logic              acc_clear, acc_load, acc_busy, acc_done;
  logic [BASE_W-1:0] acc_base;
  logic [CNT_W-1:0]  acc_count;

  logic [16:0]       lines_sum;
  logic [4:0]        lvl_sum;

  assign lines_sum = {1'b0, Lines} + {14'b0, Clear_Lines};
  assign lvl_sum   = {1'b0, lvl_cnt_q} + {2'b0, Clear_Lines};

  always_ff @(posedge CLK_25M) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      Level       <= '0;
      Lines       <= '0;
      lvl_cnt_q   <= '0;
      Level_Up    <= 1'b0;
      Clear_Ready <= 1'b0;
    end else begin
      state_q     <= state_d;
      Level       <= level_d;
      Lines       <= lines_d;
      lvl_cnt_q   <= lvl_cnt_d;
      Level_Up    <= level_up_d;
      Clear_Ready <= ready_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    level_d    = Level;
    lines_d    = Lines;
    lvl_cnt_d  = lvl_cnt_q;
    level_up_d = 1'b0;
    acc_clear  = 1'b0;
    acc_load   = 1'b0;
    acc_base   = base_score(Clear_Lines);
    acc_count  = Level[CNT_W-1:0];

    case (state_q)
      IDLE, OVER: begin
        level_d = '0;
        if (Start) begin
          state_d   = PLAY;
          level_d   = 32'd1;
          lines_d   = '0;
          lvl_cnt_d = '0;
          acc_clear = 1'b1;
        end
      end

      PLAY: begin
        if (Game_Over) begin
          state_d = OVER;
          level_d = '0;
        end else if (Clear_Valid && Clear_Ready && lines_valid(Clear_Lines)) begin
          // Score uses the pre-update level, already presented on acc_count.
          state_d  = ADD;
          acc_load = 1'b1;
          lines_d  = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
          if (lvl_sum >= LPL) begin
            lvl_cnt_d = 4'(lvl_sum - LPL);
            if (Level < MAXL) begin
              level_d    = Level + 32'd1;
              level_up_d = 1'b1;
            end
          end else begin
            lvl_cnt_d = lvl_sum[3:0];
          end
        end
      end

      ADD: begin
        // Game_Over is deliberately ignored until the score has settled.
        if (acc_done || !acc_busy) state_d = PLAY;
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == PLAY);
  end

  score_accum #(
    .SCORE_MAX(SCORE_MAX)
  ) u_score_accum (
    .clk  (CLK_25M),
    .rst_n(RST_N),
    .clear(acc_clear),
    .load (acc_load),
    .base (acc_base),
    .count(acc_count),
    .score(Score),
    .busy (acc_busy),
    .done (acc_done)
  );

endmodule
